// File: rtl/control_fsm_pkg.sv
// Shared CPU definitions: opcodes, FSM state codes, datapath select codes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Also consumed by the datapath so select encodings stay in one place.
package cpu_defs;

    // Opcode map; anything not listed here is illegal and halts the core.
    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_LUI   = 4'h3;
    localparam logic [3:0] OP_SW    = 4'h4;
    localparam logic [3:0] OP_JUMP  = 4'hF;

    // State codes are visible on the debug State output, so keep them fixed.
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_WB_ALU   = 4'd7,
        ST_WB_MEM   = 4'd8,
        ST_LUI_WB   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_HALT     = 4'd11
    } state_e;

    // ALU operand B select.
    localparam logic [1:0] ASB_REG   = 2'd0;
    localparam logic [1:0] ASB_ONE   = 2'd1;
    localparam logic [1:0] ASB_SIGNE = 2'd2;
    localparam logic [1:0] ASB_UPPER = 2'd3;

    // PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Register write-back source select.
    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MEM    = 2'd1;
    localparam logic [1:0] M2R_UPPER  = 2'd2;

    localparam logic [2:0] ALU_ADD = 3'b000;

    // Jump condition codes carried in CC for opcode F.
    localparam logic [2:0] CC_NEVER  = 3'b000;
    localparam logic [2:0] CC_ZERO   = 3'b001;
    localparam logic [2:0] CC_NEG    = 3'b010;
    localparam logic [2:0] CC_NZERO  = 3'b011;
    localparam logic [2:0] CC_NNEG   = 3'b100;
    localparam logic [2:0] CC_ALWAYS = 3'b111;

endpackage

// File: rtl/control_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// Latency: n/a (wires only).
// Backpressure: memory stalls signalled by MemReady; no other flow control.
// master = control FSM (drives enables/selects), slave = datapath/memory side.
interface control_fsm_if;
    // Instruction fields and status from the datapath
    logic [3:0] Op;
    logic [2:0] CC;
    logic       LMC;
    logic       Zero;
    logic       Neg;
    logic       MemReady;
    // Enables and selects to the datapath
    logic       IW;
    logic       PCW;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       IorD;
    logic       RegDst;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSrc;
    logic [1:0] MemToReg;
    // Status / debug
    logic       Fault;
    logic [3:0] State;

    modport master (
        input  Op, CC, LMC, Zero, Neg, MemReady,
        output IW, PCW, MemRead, MemWrite, RegWrite, IorD, RegDst,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, MemToReg, Fault, State
    );

    modport slave (
        output Op, CC, LMC, Zero, Neg, MemReady,
        input  IW, PCW, MemRead, MemWrite, RegWrite, IorD, RegDst,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, MemToReg, Fault, State
    );
endinterface

// File: rtl/control_fsm_jump_cond.sv
// Conditional-jump evaluator: decides whether the JUMP state writes the PC.
// Latency: combinational.
// Backpressure: none.
// Ports: cc (condition code), zero/neg (ALU flags) -> take (1 = jump taken).
module control_fsm_jump_cond
    import cpu_defs::*;
(
    input  logic [2:0] cc,
    input  logic       zero,
    input  logic       neg,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (cc)
            CC_ZERO:   take = zero;
            CC_NEG:    take = neg;
            CC_NZERO:  take = ~zero;
            CC_NNEG:   take = ~neg;
            CC_ALWAYS: take = 1'b1;
            // CC_NEVER and the unassigned codes never jump
            default:   take = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/write-back.
// Latency: 3-5 states per instruction plus memory wait cycles.
// Backpressure: FETCH/MEM_RD/MEM_WR stall on MemReady=0; MEM_TIMEOUT stalls -> HALT.
// Ports: CLK, Reset (async, active-high), bus (control_fsm_if.master).
module control_fsm
    import cpu_defs::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic          CLK,
    input  logic          Reset,
    control_fsm_if.master bus
);

    // The stall that brings the counter to MEM_TIMEOUT is the one that faults.
    localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [3:0] wait_q,  wait_d;
    logic       fault_q, fault_d;

    logic       jump_take;
    logic       mem_wait_state;
    logic       timeout_hit;

    control_fsm_jump_cond u_jump_cond (
        .cc   (bus.CC),
        .zero (bus.Zero),
        .neg  (bus.Neg),
        .take (jump_take)
    );

    assign mem_wait_state = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                            (state_q == ST_MEM_WR);
    assign timeout_hit    = (wait_q == TIMEOUT_LAST);

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        fault_d = fault_q;

        case (state_q)
            ST_FETCH: begin
                if (bus.MemReady)   state_d = ST_DECODE;
                else if (timeout_hit) state_d = ST_HALT;
            end
            ST_DECODE: begin
                case (bus.Op)
                    OP_RTYPE: state_d = ST_EXEC_R;
                    OP_ADDI:  state_d = ST_EXEC_I;
                    OP_LW,
                    OP_SW:    state_d = ST_MEM_ADDR;
                    OP_LUI:   state_d = ST_LUI_WB;
                    OP_JUMP:  state_d = ST_JUMP;
                    default:  state_d = ST_HALT;
                endcase
            end
            ST_EXEC_R,
            ST_EXEC_I:   state_d = ST_WB_ALU;
            ST_MEM_ADDR: begin
                // Op is held by the instruction register; anything else here
                // means the IR was corrupted, so fail safe.
                if (bus.Op == OP_LW)      state_d = ST_MEM_RD;
                else if (bus.Op == OP_SW) state_d = ST_MEM_WR;
                else                      state_d = ST_HALT;
            end
            ST_MEM_RD: begin
                if (bus.MemReady)     state_d = ST_WB_MEM;
                else if (timeout_hit) state_d = ST_HALT;
            end
            ST_MEM_WR: begin
                if (bus.MemReady)     state_d = ST_FETCH;
                else if (timeout_hit) state_d = ST_HALT;
            end
            ST_WB_ALU,
            ST_WB_MEM,
            ST_LUI_WB,
            ST_JUMP:     state_d = ST_FETCH;
            ST_HALT:     state_d = ST_HALT;
            default:     state_d = ST_HALT;
        endcase

        // Fault is sticky: only Reset clears it.
        if (state_d == ST_HALT) fault_d = 1'b1;

        // Wait counter restarts on every state entry and counts stall cycles.
        if (state_d != state_q)
            wait_d = 4'd0;
        else if (mem_wait_state && !bus.MemReady)
            wait_d = wait_q + 4'd1;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_FETCH;
            wait_q  <= 4'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    // ---------------- output decode ----------------
    logic       iw, pcw, mem_read, mem_write, reg_write, iord, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, pc_src, mem_to_reg;
    logic [2:0] alu_op;

    always_comb begin
        iw         = 1'b0;
        pcw        = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ASB_REG;
        alu_op     = ALU_ADD;
        pc_src     = PCSRC_ALU;
        mem_to_reg = M2R_ALUOUT;

        // Gating on Reset drops strobes the instant Reset rises, so an
        // in-flight write is cut off without waiting for the clock.
        if (!Reset) begin
            case (state_q)
                ST_FETCH: begin
                    // ALU computes PC+1 while the instruction is read.
                    mem_read  = 1'b1;
                    alu_src_b = ASB_ONE;
                    iw        = bus.MemReady;
                    pcw       = bus.MemReady;
                end
                ST_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ASB_REG;
                    alu_op    = bus.CC;
                end
                ST_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ASB_SIGNE;
                end
                ST_MEM_ADDR: alu_src_b = ASB_SIGNE;
                ST_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                ST_WB_ALU: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_ALUOUT;
                    reg_dst    = bus.LMC;
                end
                ST_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_MEM;
                end
                ST_LUI_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_UPPER;
                end
                ST_JUMP: begin
                    pc_src = PCSRC_JUMP;
                    pcw    = jump_take;
                end
                default: ; // DECODE and HALT drive nothing
            endcase
        end
    end

    assign bus.IW       = iw;
    assign bus.PCW      = pcw;
    assign bus.MemRead  = mem_read;
    assign bus.MemWrite = mem_write;
    assign bus.RegWrite = reg_write;
    assign bus.IorD     = iord;
    assign bus.RegDst   = reg_dst;
    assign bus.ALUSrcA  = alu_src_a;
    assign bus.ALUSrcB  = alu_src_b;
    assign bus.ALUOp    = alu_op;
    assign bus.PCSrc    = pc_src;
    assign bus.MemToReg = mem_to_reg;
    assign bus.Fault    = fault_q;
    assign bus.State    = state_q;

endmodule
